// File: rtl/div_unit_if.sv
// Request/response bundle for div_unit: operand request channel, flush, and result channel.
interface div_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [1:0]      div_op;
    logic            is_word;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, dividend, divisor, div_op, is_word, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, dividend, divisor, div_op, is_word, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV64 M-extension divider (DIV/DIVU/REM/REMU and W forms), restoring radix-2.
// Optional macro DIV_SPECIAL_BYPASS_EN: divide-by-zero / signed overflow finish in one cycle.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    div_unit_if.slave bus
);
    localparam int HALF  = XLEN / 2;
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, nextState;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   rem, quo, divMag, resultReg;
    logic              opRem, wordReg, negQ, negR;
    logic              accept, isSigned, aSign, bSign, divZero;
    logic [XLEN-1:0]   aOp, bOp, aNeg, bNeg, aMag, bMag;
    logic [XLEN:0]     shifted;
    logic              fits;
    logic [XLEN-1:0]   stepRem, stepQuo, qFixed, rFixed, pick, finalVal;

    assign bus.in_ready  = (state == IDLE) && !bus.flush;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = resultReg;
    assign accept        = bus.in_valid && bus.in_ready;

    // Operand magnitudes and sign bookkeeping, evaluated on the accepting cycle.
    always_comb begin
        isSigned = !bus.div_op[0];
        aOp      = bus.is_word ? {{HALF{1'b0}}, bus.dividend[HALF-1:0]} : bus.dividend;
        bOp      = bus.is_word ? {{HALF{1'b0}}, bus.divisor[HALF-1:0]}  : bus.divisor;
        aSign    = isSigned && (bus.is_word ? bus.dividend[HALF-1] : bus.dividend[XLEN-1]);
        bSign    = isSigned && (bus.is_word ? bus.divisor[HALF-1]  : bus.divisor[XLEN-1]);
        aNeg     = '0 - aOp;
        bNeg     = '0 - bOp;
        aMag     = aOp;
        bMag     = bOp;
        if (aSign) aMag = bus.is_word ? {{HALF{1'b0}}, aNeg[HALF-1:0]} : aNeg;
        if (bSign) bMag = bus.is_word ? {{HALF{1'b0}}, bNeg[HALF-1:0]} : bNeg;
        divZero  = (bOp == '0);
    end

`ifdef DIV_SPECIAL_BYPASS_EN
    logic            specialReg, overflow, bypass;
    logic [XLEN-1:0] specialVal;

    always_comb begin
        overflow = isSigned && (bus.is_word
            ? (aOp[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) && (bOp[HALF-1:0] == '1)
            : (aOp == {1'b1, {(XLEN-1){1'b0}}}) && (bOp == '1));
        bypass = divZero || overflow;
        if (divZero)
            specialVal = !bus.div_op[1] ? '1 : (bus.is_word
                ? {{HALF{bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]} : bus.dividend);
        else
            specialVal = bus.div_op[1] ? '0 : (bus.is_word
                ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}});
    end
`endif

    // One restoring step; the shifted partial remainder is XLEN+1 bits wide.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        fits     = shifted >= {1'b0, divMag};
        stepRem  = fits ? XLEN'(shifted - {1'b0, divMag}) : shifted[XLEN-1:0];
        stepQuo  = {quo[XLEN-2:0], fits};
        qFixed   = negQ ? '0 - stepQuo : stepQuo;
        rFixed   = negR ? '0 - stepRem : stepRem;
        pick     = opRem ? rFixed : qFixed;
        finalVal = wordReg ? {{HALF{pick[HALF-1]}}, pick[HALF-1:0]} : pick;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (accept) nextState = CALC;
            CALC: if (cnt == CNT_W'(1)) nextState = DONE;
            DONE: if (bus.out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (bus.flush) nextState = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            divMag    <= '0;
            resultReg <= '0;
            opRem     <= 1'b0;
            wordReg   <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
`ifdef DIV_SPECIAL_BYPASS_EN
            specialReg <= 1'b0;
`endif
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept) begin
            rem     <= '0;
            quo     <= bus.is_word ? {aMag[HALF-1:0], {HALF{1'b0}}} : aMag;
            divMag  <= bMag;
            opRem   <= bus.div_op[1];
            wordReg <= bus.is_word;
            negQ    <= (aSign ^ bSign) && !divZero;
            negR    <= aSign;
            cnt     <= bus.is_word ? CNT_W'(HALF) : CNT_W'(XLEN);
`ifdef DIV_SPECIAL_BYPASS_EN
            // Special cases take one pass through CALC with the answer preloaded.
            specialReg <= bypass;
            if (bypass) begin
                cnt       <= CNT_W'(1);
                resultReg <= specialVal;
            end
`endif
        end else if (state == CALC) begin
            rem <= stepRem;
            quo <= stepQuo;
            cnt <= cnt - CNT_W'(1);
`ifdef DIV_SPECIAL_BYPASS_EN
            if (cnt == CNT_W'(1) && !specialReg) resultReg <= finalVal;
`else
            if (cnt == CNT_W'(1)) resultReg <= finalVal;
`endif
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_unit_if #(.XLEN(64)) bus ();
    div_unit #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] refModel(input logic [1:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        int              sa, sb;
        int unsigned     ua, ub;
        longint          la, lb;
        longint unsigned va, vb;
        logic [31:0]     q32, r32, p32;
        logic [63:0]     q, r;
        ua = a[31:0]; ub = b[31:0]; sa = a[31:0]; sb = b[31:0];
        va = a; vb = b; la = a; lb = b;
        if (w) begin
            if (ub == 0) begin q32 = '1; r32 = ua; end
            else if (!op[0] && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin q32 = 32'h8000_0000; r32 = '0; end
            else if (!op[0]) begin q32 = sa / sb; r32 = sa % sb; end
            else begin q32 = ua / ub; r32 = ua % ub; end
            p32 = op[1] ? r32 : q32;
            return {{32{p32[31]}}, p32};
        end
        if (vb == 0) begin q = '1; r = va; end
        else if (!op[0] && va == 64'h8000_0000_0000_0000 && vb == '1) begin q = 64'h8000_0000_0000_0000; r = '0; end
        else if (!op[0]) begin q = la / lb; r = la % lb; end
        else begin q = va / vb; r = va % vb; end
        return op[1] ? r : q;
    endfunction

    function automatic int expLatency(input logic [1:0] op, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        logic special;
        if (w) special = (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        else   special = (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
`ifdef DIV_SPECIAL_BYPASS_EN
        if (special) return 1;
`endif
        if (special) return w ? 32 : 64;
        return w ? 32 : 64;
    endfunction

    task automatic runOp(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input int hold, input string tag);
        logic [63:0] exp;
        int          expLat, lat;
        logic        seen;
        exp    = refModel(op, w, a, b);
        expLat = expLatency(op, w, a, b);
        @(negedge clk);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.div_op    = op;
        bus.is_word   = w;
        bus.dividend  = a;
        bus.divisor   = b;
        checks++;
        assert (bus.in_ready === 1'b1) else begin
            errors++; $error("FAIL %s in_ready got %b exp 1", tag, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (lat < 200 && !seen) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = bus.out_valid;
        end
        checks++;
        assert (seen && lat === expLat) else begin
            errors++; $error("FAIL %s latency got %0d exp %0d", tag, lat, expLat);
        end
        checks++;
        assert (bus.result === exp) else begin
            errors++; $error("FAIL %s result got %h exp %h", tag, bus.result, exp);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            assert (bus.out_valid === 1'b1 && bus.in_ready === 1'b0 && bus.result === exp) else begin
                errors++; $error("FAIL %s hold%0d valid %b ready %b result %h exp %h",
                                 tag, i, bus.out_valid, bus.in_ready, bus.result, exp);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic watchNoValid(input int cycles, input string tag);
        logic saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        checks++;
        assert (saw === 1'b0) else begin
            errors++; $error("FAIL %s out_valid got 1 exp 0", tag);
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        int          mode;

        bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.div_op = '0;
        bus.is_word = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        checks++;
        assert (bus.out_valid === 1'b0 && bus.result === 64'h0) else begin
            errors++; $error("FAIL reset valid %b result %h exp 0/0", bus.out_valid, bus.result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        assert (bus.in_ready === 1'b1) else begin
            errors++; $error("FAIL reset_release in_ready got %b exp 1", bus.in_ready);
        end

        runOp(2'b00, 1'b0, -64'sd7, 64'd2, 0, "div_m7_2");
        runOp(2'b10, 1'b0, -64'sd7, 64'd2, 0, "rem_m7_2");
        runOp(2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 0, "divuw_sext");
        runOp(2'b01, 1'b0, 64'd5, 64'd0, 0, "divu_zero");
        runOp(2'b11, 1'b0, 64'd5, 64'd0, 0, "remu_zero");
        runOp(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "div_ovf");
        runOp(2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 0, "rem_ovf");
        runOp(2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF, 0, "divw_ovf");
        runOp(2'b10, 1'b1, 64'h0000_0000_8000_0001, 64'd0, 0, "remw_zero");
        runOp(2'b00, 1'b0, 64'd1000, 64'd7, 10, "hold");
        runOp(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 0, "after_hold");

        // Flush at iteration 20.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.div_op = 2'b00; bus.is_word = 1'b0;
        bus.dividend = 64'd100; bus.divisor = 64'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        assert (bus.out_valid === 1'b0 && bus.in_ready === 1'b1) else begin
            errors++; $error("FAIL flush valid %b ready %b exp 0/1", bus.out_valid, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        #1;
        checks++;
        assert (bus.in_ready === 1'b0) else begin
            errors++; $error("FAIL flush_in_ready got %b exp 0", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        watchNoValid(80, "flush_no_output");

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.dividend = 64'd999; bus.divisor = 64'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (bus.out_valid === 1'b0 && bus.result === 64'h0) else begin
            errors++; $error("FAIL rst_mid valid %b result %h exp 0/0", bus.out_valid, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        assert (bus.in_ready === 1'b1) else begin
            errors++; $error("FAIL rst_mid_ready got %b exp 1", bus.in_ready);
        end
        watchNoValid(80, "rst_no_output");

        for (int n = 0; n < 40; n++) begin
            op   = 2'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            a    = {$urandom, $urandom};
            mode = $urandom_range(0, 7);
            if (mode == 0) b = '0;
            else if (mode == 1) begin
                b = '1;
                a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
            end else if (mode == 2) b = 64'($urandom_range(1, 20));
            else if (mode == 3) b = -64'($urandom_range(1, 20));
            else b = {$urandom, $urandom} >> $urandom_range(0, 62);
            runOp(op, w, a, b, $urandom_range(0, 2), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
